// File: rtl/sop_chk_pkg.sv
// sop_chk_pkg: state encoding and constants shared by the SOP vector checker.
package sop_chk_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} sop_chk_state_t;
  localparam logic [7:0] SOP_EXPECTED_DEFAULT = 8'h31;
  localparam int SOP_NUM_VECTORS = 8;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: 8-bit loadable down-counter; expired while the count is zero.
module settle_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);
  logic [7:0] count;
  assign expired = count == 8'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= 8'd0;
    else count <= load ? load_val : (expired ? count : count - 8'd1);
endmodule

// File: rtl/sop_vector_checker.sv
// sop_vector_checker: sweeps {a,b,c} through all 8 vectors and checks y against EXPECTED.
// Define SOP_CHK_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module sop_vector_checker
  import sop_chk_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED      = SOP_EXPECTED_DEFAULT,
  parameter int         ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       vec_idx
);
  sop_chk_state_t state, state_nx;
  logic accept, load, expired, miss, stop, last;
  logic [ERR_W-1:0] err_nx;

  assign {a, b, c} = vec_idx;
  assign accept = state == IDLE && start;
  assign miss = state == CHECK && y != EXPECTED[vec_idx];
  assign err_nx = miss && !(&err_count) ? err_count + 1'b1 : err_count;
`ifdef SOP_CHK_STOP_ON_ERR_EN
  assign stop = miss;
`else
  assign stop = 1'b0;
`endif
  assign last = vec_idx == 3'(SOP_NUM_VECTORS - 1) || stop;

  settle_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .load_val(8'(SETTLE_CYCLES - 1)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    load = 1'b0;
    case (state)
      IDLE: begin
        state_nx = start ? SETTLE : IDLE;
        load = start;
      end
      SETTLE: state_nx = expired ? CHECK : SETTLE;
      CHECK: begin
        state_nx = last ? DONE : SETTLE;
        load = !last;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Every output is a flop fed from next-state values, so y/start never reach an output combinationally.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vec_idx   <= 3'd0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      busy     <= state_nx != IDLE;
      done     <= state_nx == DONE;
      mismatch <= miss;
      if (accept) begin
        vec_idx   <= 3'd0;
        err_count <= '0;
        pass      <= 1'b0;
      end else begin
        err_count <= err_nx;
        if (load) vec_idx <= vec_idx + 3'd1;
        if (state_nx == DONE) pass <= err_nx == '0;
      end
    end
endmodule

// File: doc/sop_vector_checker.md
# sop_vector_checker

Self-checking exhaustive stimulus driver for the 3-input sum-of-products block in the chapter-4 examples. It drives `a`, `b`, `c` through all 8 input combinations and waits a programmable number of clocks for the combinational path to settle. It then samples `y`, compares it against a parameterised truth table, and reports a mismatch count and a pass/fail verdict. It sits opposite the SOP block in synthesizable self-test tops, in place of the `$monitor`-style testbench.

## Interface
- `SETTLE_CYCLES`, 4: clocks held per vector before `y` is sampled; legal range 1..255.
- `EXPECTED`, 8'h31: expected `y` per vector; bit `i` is the expected `y` for `{a,b,c} == i`. The default is 1 at vectors 000, 100 and 101.
- `ERR_W`, 4: width of the error counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: single-cycle request to run a sweep.
- `a`, `b`, `c` out 1 each: registered stimulus to the DUT.
- `y` in 1: DUT output, sampled only in CHECK.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `pass` out 1: high when the last sweep had zero mismatches; held until the next `start` is accepted.
- `mismatch` out 1: one-cycle pulse in any CHECK cycle where `y != EXPECTED[idx]`.
- `err_count` out ERR_W: count of mismatches; saturates at all-ones.
- `vec_idx` out 3: index of the vector currently applied; always equals `{a,b,c}`.

## Operation
- States:
  - IDLE: waiting for `start`.
  - SETTLE: vector applied, settle timer counting.
  - CHECK: sample and compare `y`.
  - DONE: sweep complete.
- IDLE -> SETTLE on `start`:
  - `vec_idx` and `{a,b,c}` load 0.
  - `err_count` clears, `pass` clears, and the timer loads `SETTLE_CYCLES-1`.
- SETTLE: the timer decrements once per clock. It moves to CHECK in the cycle after the timer reads 0.
- CHECK:
  - Compare `y` with `EXPECTED[vec_idx]`.
  - On a mismatch, pulse `mismatch` and increment `err_count` unless it is already saturated.
  - If `vec_idx == 7`, go to DONE.
  - Otherwise increment `vec_idx`, reload the timer, and go to SETTLE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - `pass` is set to (`err_count` after the final compare `== 0`).
  - Go to IDLE.
- `start` is ignored whenever the state is not IDLE.
- `y` is never sampled outside CHECK, so glitches during SETTLE are invisible by construction.
- Reset at any point, including mid-sweep, forces IDLE immediately. All outputs return to their reset values and the partial result is discarded.

## Timing
- Reset values:
  - `a`, `b`, `c`, `vec_idx` = 0.
  - `busy`, `done`, `pass`, `mismatch` = 0.
  - `err_count` = 0.
  - Timer = 0.
- All outputs are registered, and there is no combinational path from `y` or `start` to any output.
- `start` is sampled high in cycle T. Then:
  - T+1: `busy` = 1 and vector 0 is on `a`, `b`, `c`.
  - T+1 .. T+SETTLE_CYCLES: SETTLE.
  - T+SETTLE_CYCLES+1: CHECK for vector 0.
  - The next vector appears one cycle after its predecessor's CHECK.
- Per-vector period is `SETTLE_CYCLES+1` clocks, so a full sweep is `8*(SETTLE_CYCLES+1)` clocks of CHECK/SETTLE plus 1 DONE cycle.
- Timing of pulses:
  - `mismatch` rises in the cycle following the failing CHECK cycle and lasts 1 clock.
  - `err_count` updates on the same edge as `mismatch`.
  - `done` and the final `pass` update together on the same edge.
- `SETTLE_CYCLES` must cover the DUT's worst-case path delay divided by the clock period. The block does not check this.

## Configuration
- `SOP_CHK_STOP_ON_ERR_EN`
  - Defined: the first mismatching CHECK goes straight to DONE. `vec_idx` and `{a,b,c}` hold the failing vector until the next `start`, `err_count` = 1, and `pass` = 0.
  - Undefined: the sweep always covers all 8 vectors, and `err_count` reports the total number of mismatches.

## Structure
- Package `sop_chk_pkg` holds:
  - The state enum `sop_chk_state_t` (IDLE, SETTLE, CHECK, DONE).
  - The constant `SOP_EXPECTED_DEFAULT = 8'h31`.
  - The constant `SOP_NUM_VECTORS = 8`.
- One sub-module, `settle_timer`:
  - 8-bit loadable down-counter with inputs `load` and `load_val`.
  - Output `expired` is high while the count is 0.
  - Uses the same `clk`/`reset_n`.

## Test plan
- Reset check: hold `reset_n` = 0 for 3 clocks with `start` = 1 -> all outputs 0; after release, with `start` = 0, the block stays in IDLE with `busy` = 0.
- Correct DUT, SETTLE_CYCLES = 4, `start` at T -> vectors 0..7 each applied 5 clocks, 8 CHECKs, `done` at T+41, `pass` = 1, `err_count` = 0, no `mismatch` pulses.
- DUT model with `y` stuck at 0 -> 3 mismatches at `vec_idx` 0, 4 and 5; `err_count` = 3, `pass` = 0. With `SOP_CHK_STOP_ON_ERR_EN` defined: `done` at T+6, `vec_idx` = 0, `err_count` = 1.
- ERR_W = 2, DUT output `y` = ~expected -> 8 mismatch pulses, `err_count` saturates at 3, `pass` = 0.
- Drive `start` high during SETTLE of vector 3 -> ignored; the sweep completes unchanged, with a single `done` pulse.
- Assert `reset_n` low during CHECK of vector 5 -> immediately IDLE with all outputs 0; a new `start` then runs a complete, clean sweep with `pass` = 1.
